// File: rtl/alu_writeback.sv
// Writeback stage behind the dual-result ALU: serialises q0/q1 onto the single
// register-file write port and owns the architectural V/C/Z/N flags.
module alu_writeback #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [31:0]      in_q0,
  input  logic [31:0]      in_q1,
  input  logic [3:0]       in_st,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             busy
);

  localparam logic [7:0] OP_MUL = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR0  = 2'b01,
    ST_WR1  = 2'b10
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [7:0]        op_r;
  logic [RA_W-1:0]   rd_r;
  logic [31:0]       q1_r;
  logic              ready_s;
  logic              accept_s;
  logic              we_nxt_s;
  logic [RA_W-1:0]   waddr_nxt_s;
  logic [31:0]       wdata_nxt_s;

  function automatic logic op_defined(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h11);
  endfunction

  function automatic logic op_illegal(input logic [7:0] op);
    return (op >= 8'h12);
  endfunction

  assign accept_s = in_valid && ready_s;
  assign in_ready = ready_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a latched MUL always spends one extra cycle in WR1
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_WR0;
        else          state_nxt_s = ST_IDLE;
      end
      ST_WR0: begin
        if (op_r == OP_MUL) state_nxt_s = ST_WR1;
        else if (accept_s)  state_nxt_s = ST_WR0;
        else                state_nxt_s = ST_IDLE;
      end
      ST_WR1: begin
        if (accept_s) state_nxt_s = ST_WR0;
        else          state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake decode: only the MUL low-word cycle refuses a new bundle
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      ST_WR0:  ready_s = (op_r != OP_MUL);
      ST_WR1:  ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Write-port selection for the cycle that the next edge enters
  always_comb begin
    we_nxt_s    = 1'b0;
    waddr_nxt_s = rf_waddr;
    wdata_nxt_s = rf_wdata;
    if (accept_s) begin
      we_nxt_s    = op_defined(in_op);
      waddr_nxt_s = in_rd;
      wdata_nxt_s = in_q0;
    end else if ((state_r == ST_WR0) && (op_r == OP_MUL)) begin
      we_nxt_s    = 1'b1;
      waddr_nxt_s = rd_r + RA_W'(1);
      wdata_nxt_s = q1_r;
    end else begin
      we_nxt_s    = 1'b0;
      waddr_nxt_s = rf_waddr;
      wdata_nxt_s = rf_wdata;
    end
  end

  // Bundle capture; q0 goes straight to the write-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= 8'h00;
      rd_r <= '0;
      q1_r <= 32'h0000_0000;
    end else if (accept_s) begin
      op_r <= in_op;
      rd_r <= in_rd;
      q1_r <= in_q1;
    end
  end

  // Registered write port and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= 32'h0000_0000;
      busy     <= 1'b0;
    end else begin
      rf_we    <= we_nxt_s;
      rf_waddr <= waddr_nxt_s;
      rf_wdata <= wdata_nxt_s;
      busy     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Flags and illegal-opcode counter update only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags       <= 4'b0000;
      illegal_cnt <= '0;
    end else if (accept_s) begin
      if (op_defined(in_op)) flags <= in_st;
      if (op_illegal(in_op) && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: a queue-of-writes model scored every
// cycle, plus literal checks on the directed scenarios.
module tb_alu_writeback;
  localparam int RA_W  = 4;
  localparam int CNT_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_op = 8'h00;
  logic [RA_W-1:0] in_rd = '0;
  logic [31:0]     in_q0 = 32'h0;
  logic [31:0]     in_q1 = 32'h0;
  logic [3:0]      in_st = 4'h0;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [31:0]     rf_wdata;
  logic [3:0]      flags;
  logic [CNT_W-1:0] illegal_cnt;
  logic            busy;

  always #5 clk = ~clk;

  alu_writeback #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_q0(in_q0), .in_q1(in_q1), .in_st(in_st),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags(flags),
    .illegal_cnt(illegal_cnt), .busy(busy)
  );

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] a;
    logic [31:0]     d;
  } wr_t;

  // Model: every accepted bundle schedules one write slot per output cycle
  wr_t             sched[$];
  logic            m_we, m_busy;
  logic [RA_W-1:0] m_waddr;
  logic [31:0]     m_wdata;
  logic [3:0]      m_flags;
  int              m_cnt;

  wr_t wlog[$];
  int  nr_cnt = 0;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    sched.delete();
    m_we = 1'b0; m_busy = 1'b0; m_waddr = '0; m_wdata = 32'h0;
    m_flags = 4'h0; m_cnt = 0;
  endtask

  // Advance one clock edge and update the model from the bench's own inputs
  task automatic step();
    wr_t             e;
    logic            acc, def;
    logic [RA_W-1:0] rd1;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid && (sched.size() == 0);
      if (acc) begin
        def = (in_op >= 8'h01) && (in_op <= 8'h11);
        sched.push_back('{def, in_rd, in_q0});
        if (in_op == 8'h04) begin
          rd1 = in_rd + 4'd1;
          sched.push_back('{1'b1, rd1, in_q1});
        end
        if (def) m_flags = in_st;
        if (in_op >= 8'h12 && m_cnt < 255) m_cnt++;
      end
      if (sched.size() > 0) begin
        e = sched.pop_front();
        m_we = e.we; m_waddr = e.a; m_wdata = e.d; m_busy = 1'b1;
      end else begin
        m_we = 1'b0; m_busy = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [RA_W-1:0] rd,
                      input logic [31:0] q0, input logic [31:0] q1, input logic [3:0] st);
    int tries = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_q0 = q0; in_q1 = q1; in_st = st;
    while (!done && tries < 4) begin
      done = (sched.size() == 0);
      step();
      tries++;
    end
    chk("accept_timeout", done, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
    @(negedge clk);
  endtask

  // Per-cycle scoreboard against the model
  always @(negedge clk) begin
    chk("in_ready", in_ready, (sched.size() == 0));
    chk("busy", busy, m_busy);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("flags", flags, m_flags);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (rf_we === 1'b1) wlog.push_back('{1'b1, rf_waddr, rf_wdata});
    if (in_ready !== 1'b1) nr_cnt++;
  end

  initial begin
    int hits;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_cnt", illegal_cnt, 8'h00);

    // Back-to-back ADDs
    wlog.delete(); nr_cnt = 0;
    send(8'h01, 4'd1, 32'h11, 32'h0, 4'h0);
    send(8'h01, 4'd2, 32'h22, 32'h0, 4'h4);
    send(8'h01, 4'd3, 32'h33, 32'h0, 4'h8);
    idle(2);
    #2;
    chk("add_n", wlog.size(), 32'd3);
    chk("add0_a", wlog[0].a, 4'd1); chk("add0_d", wlog[0].d, 32'h11);
    chk("add1_a", wlog[1].a, 4'd2); chk("add1_d", wlog[1].d, 32'h22);
    chk("add2_a", wlog[2].a, 4'd3); chk("add2_d", wlog[2].d, 32'h33);
    chk("add_flags", flags, 4'h8);
    chk("add_stall", nr_cnt, 32'd0);

    // MUL followed immediately by ADD
    wlog.delete(); nr_cnt = 0;
    send(8'h04, 4'd5, 32'hDEADBEEF, 32'h00000001, 4'h2);
    send(8'h01, 4'd7, 32'h77, 32'h0, 4'h1);
    idle(2);
    #2;
    chk("mul_n", wlog.size(), 32'd3);
    chk("mul0_a", wlog[0].a, 4'd5); chk("mul0_d", wlog[0].d, 32'hDEADBEEF);
    chk("mul1_a", wlog[1].a, 4'd6); chk("mul1_d", wlog[1].d, 32'h00000001);
    chk("mul_add_a", wlog[2].a, 4'd7); chk("mul_add_d", wlog[2].d, 32'h77);
    chk("mul_stall", nr_cnt, 32'd1);
    chk("mul_add_flags", flags, 4'h1);

    // MUL address wrap
    wlog.delete();
    send(8'h04, 4'd15, 32'h0000000A, 32'h0000000B, 4'h0);
    idle(2);
    #2;
    chk("wrap_n", wlog.size(), 32'd2);
    chk("wrap0_a", wlog[0].a, 4'd15);
    chk("wrap1_a", wlog[1].a, 4'd0); chk("wrap1_d", wlog[1].d, 32'h0000000B);

    // NOP and invalid opcodes leave writes and flags alone
    send(8'h01, 4'd1, 32'h1, 32'h0, 4'h4);
    idle(1);
    wlog.delete();
    send(8'h00, 4'd2, 32'h5, 32'h0, 4'hF);
    send(8'h12, 4'd3, 32'h6, 32'h0, 4'hF);
    send(8'hFF, 4'd4, 32'h7, 32'h0, 4'hF);
    idle(2);
    #2;
    chk("nop_writes", wlog.size(), 32'd0);
    chk("nop_flags", flags, 4'h4);
    chk("nop_cnt", illegal_cnt, 8'd2);

    // Saturation of the illegal counter
    for (int i = 0; i < 300; i++) send(8'h80, 4'd0, 32'h0, 32'h0, 4'h0);
    idle(1);
    #2;
    chk("sat_cnt", illegal_cnt, 8'hFF);
    chk("sat_flags", flags, 4'h4);

    // Reset in the low-word cycle of a MUL
    wlog.delete();
    send(8'h04, 4'd9, 32'h99, 32'h1010, 4'h3);
    #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mrst_we", rf_we, 1'b0);
    chk("mrst_waddr", rf_waddr, 4'd0);
    chk("mrst_wdata", rf_wdata, 32'h0);
    chk("mrst_flags", flags, 4'h0);
    chk("mrst_cnt", illegal_cnt, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    #2;
    hits = 0;
    foreach (wlog[i]) if (wlog[i].a == 4'd10) hits++;
    chk("mrst_no_hi", hits, 32'd0);
    chk("mrst_log_n", wlog.size(), 32'd1);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage sitting directly downstream of the 32-bit dual-result ALU. It accepts one ALU result bundle per handshake: opcode, destination register, `q0`, `q1` and the 4-bit status. It sequences the results onto the register file's single write port: one write for single-result ops, two consecutive writes for MUL, where the high word goes to `rd+1`. It also holds the architectural V/C/Z/N flags register.

## Interface
Parameters:
- `RA_W`, default 4: register-file address width. `rd+1` wraps modulo 2^RA_W.
- `CNT_W`, default 8: width of the illegal-opcode counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock; no other clock domains.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  stage can accept a bundle this cycle. Combinational from state only.
- `in_op`  in  8  ALU opcode, same encoding as the ALU: 0x00 NOP, 0x01–0x11 defined, 0x04 MUL, 0x12–0xFF invalid.
- `in_rd`  in  RA_W  destination register.
- `in_q0`  in  32  ALU low/primary result.
- `in_q1`  in  32  ALU high result (meaningful for MUL only).
- `in_st`  in  4  ALU status: bit0 V, bit1 C, bit2 Z, bit3 N.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_waddr`  out  RA_W  write address (registered).
- `rf_wdata`  out  32  write data (registered).
- `flags`  out  4  architectural flags, same bit order as `in_st` (registered).
- `illegal_cnt`  out  CNT_W  saturating count of accepted invalid opcodes.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WR0 (primary write cycle), WR1 (MUL high-word write cycle).
- Accept = `in_valid && in_ready`. On accept the stage latches op, rd, q0 and q1.
- `in_ready` is:
  - 1 in IDLE;
  - 1 in WR0 only if the latched op ≠ MUL;
  - 1 in WR1;
  - otherwise 0.
- Transitions:
  - IDLE: accept → WR0; otherwise stay.
  - WR0 with latched MUL → WR1, unconditionally. `in_ready` is 0 here, so nothing is accepted.
  - WR0 with non-MUL: accept → WR0 (new bundle); otherwise → IDLE.
  - WR1: accept → WR0; otherwise → IDLE.
- Register-file outputs are driven by the edge that enters each state:
  - WR0: `rf_waddr`=rd, `rf_wdata`=q0, `rf_we`=1 for opcodes 0x01–0x11; `rf_we`=0 for NOP and invalid opcodes.
  - WR1: `rf_waddr`=(rd+1) mod 2^RA_W, `rf_wdata`=q1, `rf_we`=1.
  - IDLE: `rf_we`=0. `rf_waddr` and `rf_wdata` hold their last values.
- Flags:
  - Loaded from `in_st` on the accept edge for opcodes 0x01–0x11.
  - Unchanged for NOP and invalid opcodes.
  - MUL loads flags once, at accept; WR1 does not touch flags.
- `illegal_cnt`: increments on the accept edge of any opcode ≥ 0x12 and saturates at all-ones. NOP is not illegal.
- Simultaneous events: in WR0 (non-MUL) and WR1, the outgoing write and the next accept happen on the same edge with no bubble.

## Timing
- Reset values:
  - state IDLE, so `in_ready`=1 and `busy`=0;
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0;
  - `flags`=0000;
  - `illegal_cnt`=0.
- Latency: accept at edge E means `rf_we` is asserted in the cycle after E, and `flags` is visible from that same cycle. For MUL, the high write follows one cycle later.
- Throughput:
  - non-MUL: one bundle per cycle;
  - MUL: one bundle per two cycles, with exactly one cycle of `in_ready`=0 during its WR0.
- `in_*` are sampled only on accept edges. Values presented while `in_ready`=0 are ignored and must be held by upstream.
- Reset mid-operation (e.g. during WR0 of a MUL): the pending WR1 is abandoned, and `rf_we` drops asynchronously to 0. No partial write is completed after reset release.
- Address wrap: MUL with rd=2^RA_W−1 writes the high word to register 0.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-run.
  - Required: all outputs at reset values within the same cycle; `in_ready`=1 after release; no `rf_we` until the first accept.
- Back-to-back ADD: three consecutive valid ADDs to rd=1,2,3 with q0=0x11,0x22,0x33 and st=0x0,0x4,0x8.
  - Required: `rf_we`=1 for three consecutive cycles with (1,0x11),(2,0x22),(3,0x33); `flags` 0x0, 0x4, 0x8 in step; `in_ready` never drops.
- MUL pair plus stall: MUL rd=5, q0=0xDEADBEEF, q1=0x00000001, st=0x2, followed immediately by ADD rd=7.
  - Required: writes (5,0xDEADBEEF) then (6,0x00000001) on consecutive cycles; `in_ready`=0 for exactly one cycle; the ADD write lands the cycle after WR1; `flags`=0x2 until the ADD updates it.
- MUL wrap: MUL rd=15 with RA_W=4.
  - Required: second write goes to address 0.
- NOP/invalid: NOP with st=0xF, then op=0x12, then op=0xFF, after flags=0x4.
  - Required: `rf_we` stays 0; `flags` stays 0x4; `illegal_cnt` goes 0→1→2.
  - Also force 300 invalid accepts with CNT_W=8: `illegal_cnt` saturates at 0xFF.
- Reset during MUL: assert `rst_n` low in the WR0 cycle of a MUL.
  - Required: no write to rd+1 ever occurs; state IDLE after release.
